// File: rtl/mpu_matrix_loader.sv
// Serial-to-parallel loader: packs DIM*DIM signed elements (row-major) into a
// flat matrix register and hands it downstream via valid/ready.
// Optional: define MPU_LOADER_ZERO_PAD_EN to add in_last (early completion with zero fill).
module mpu_matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W-1:0]          in_data,
`ifdef MPU_LOADER_ZERO_PAD_EN
  input  logic                       in_last,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W*DIM*DIM-1:0]  matrix,
  output logic [4:0]                 count
);

  localparam int unsigned N = DIM * DIM;
  localparam logic [4:0] LAST_IDX  = 5'(N - 1);
  localparam logic [4:0] FULL_CNT  = 5'(N);

  typedef enum logic {LOAD, FULL} state_t;
  state_t state;

  logic pad;
  logic done;

`ifdef MPU_LOADER_ZERO_PAD_EN
  assign pad = in_last;
`else
  assign pad = 1'b0;
`endif

  assign done      = pad || (count == LAST_IDX);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      count  <= '0;
      matrix <= '0;
    end else if (clear) begin
      state  <= LOAD;
      count  <= '0;
      matrix <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            // Slot at count takes the element; with in_last, every later slot is zeroed in the same edge.
            for (int unsigned k = 0; k < N; k++) begin
              if (k == 32'(count))
                matrix[ELEM_W*k +: ELEM_W] <= in_data;
              else if (pad && (k > 32'(count)))
                matrix[ELEM_W*k +: ELEM_W] <= '0;
            end
            if (done) begin
              count <= FULL_CNT;
              state <= FULL;
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state <= LOAD;
            count <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: vector table, directed corner
// sequences and randomized traffic against a slot-array reference model.
module tb_mpu_matrix_loader;
  localparam int N = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [199:0] matrix;
  logic [4:0]   count;
`ifdef MPU_LOADER_ZERO_PAD_EN
  logic         in_last = 1'b0;
`endif

  int unsigned total = 0;
  int unsigned passed = 0;

  // Reference model: slot array, element count, full flag
  logic [7:0] m_slot [N];
  int         m_cnt;
  bit         m_full;

  mpu_matrix_loader #(.ELEM_W(8), .DIM(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef MPU_LOADER_ZERO_PAD_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .matrix(matrix),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         clr;
    bit         v;
    logic [7:0] d;
    logic [4:0] cnt;
    logic [7:0] s0;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [199:0] m_pack();
    logic [199:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[8*k +: 8] = m_slot[k];
    return p;
  endfunction

  function automatic logic [7:0] tr_slot(logic [199:0] mat, int k);
    int r, c;
    r = k / 5;
    c = k % 5;
    return mat[8*(5*c + r) +: 8];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_slot[k] = '0;
    m_cnt  = 0;
    m_full = 0;
  endtask

  task automatic model_edge(bit clr, bit v, logic [7:0] d, bit ordy, bit last);
    if (clr) begin
      model_reset();
    end else if (m_full) begin
      if (ordy) begin
        m_full = 0;
        m_cnt  = 0;
      end
    end else if (v) begin
      m_slot[m_cnt] = d;
      if (last) begin
        for (int k = m_cnt + 1; k < N; k++) m_slot[k] = '0;
        m_cnt = N;
      end else begin
        m_cnt++;
      end
      if (m_cnt == N) m_full = 1;
    end
  endtask

  task automatic chk(string nm, logic [199:0] act, logic [199:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_model(string nm);
    chk({nm, "_cnt"}, 200'(count), 200'(m_cnt));
    chk({nm, "_ov"}, 200'(out_valid), 200'(m_full));
    chk({nm, "_ir"}, 200'(in_ready), 200'(!m_full));
    chk({nm, "_mat"}, matrix, m_pack());
  endtask

  task automatic cycle(bit clr, bit v, logic [7:0] d, bit ordy, bit last);
    clear     = clr;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
`ifdef MPU_LOADER_ZERO_PAD_EN
    in_last   = last;
`endif
    @(posedge clk);
    model_edge(clr, v, d, ordy, last);
    #1;
  endtask

  task automatic stream(int n, int base, bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 1, 8'(base + i), ordy, 0);
  endtask

  initial begin
    logic [199:0] snap;
    logic [7:0]   g [N];
    int           idx;
    bit           v;

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cnt", 200'(count), 200'd0);
    chk("rst_mat", matrix, 200'd0);
    chk("rst_ov", 200'(out_valid), 200'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ir", 200'(in_ready), 200'd1);

    // Vector table: clear, valid, data -> count, slot0 after the edge
    tbl[0] = '{0, 0, 8'hAA, 5'd0, 8'h00};
    tbl[1] = '{0, 1, 8'h80, 5'd1, 8'h80};
    tbl[2] = '{0, 1, 8'h7F, 5'd2, 8'h80};
    tbl[3] = '{0, 0, 8'h33, 5'd2, 8'h80};
    tbl[4] = '{1, 1, 8'h55, 5'd0, 8'h00};
    tbl[5] = '{0, 1, 8'h11, 5'd1, 8'h11};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].clr, tbl[i].v, tbl[i].d, 0, 0);
      chk("tbl_cnt", 200'(count), 200'(tbl[i].cnt));
      chk("tbl_s0", 200'(matrix[7:0]), 200'(tbl[i].s0));
      chk("tbl_ir", 200'(in_ready), 200'd1);
    end
    cycle(1, 0, 0, 0, 0);

    // 1..25 back-to-back with out_ready high
    for (int i = 0; i < N; i++) begin
      cycle(0, 1, 8'(i + 1), 1, 0);
      if (i == N - 2) chk("s1_ov_before", 200'(out_valid), 200'd0);
    end
    chk("s1_ov", 200'(out_valid), 200'd1);
    chk("s1_cnt", 200'(count), 200'd25);
    chk("s1_slot0", 200'(matrix[7:0]), 200'd1);
    chk("s1_slot24", 200'(matrix[199:192]), 200'd25);
    chk("s1_mat", matrix, m_pack());
    chk("s1_tr1", 200'(tr_slot(matrix, 1)), 200'd6);
    chk("s1_tr5", 200'(tr_slot(matrix, 5)), 200'd2);
    cycle(0, 1, 8'd77, 1, 0);
    chk("s1_rel_ov", 200'(out_valid), 200'd0);
    chk("s1_rel_ir", 200'(in_ready), 200'd1);
    chk("s1_rel_cnt", 200'(count), 200'd0);
    chk("s1_nobypass", 200'(matrix[7:0]), 200'd1);

    // Backpressure while FULL
    stream(N, 1, 0);
    snap = m_pack();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'd99, 0, 0);
      chk("bp_ir", 200'(in_ready), 200'd0);
      chk("bp_cnt", 200'(count), 200'd25);
      chk("bp_mat", matrix, snap);
    end
    cycle(0, 0, 0, 1, 0);
    chk("bp_rel_cnt", 200'(count), 200'd0);

    // Extreme values with random gaps
    g[0] = 8'h80; g[1] = 8'h7F; g[2] = 8'hFF; g[3] = 8'h00;
    for (int i = 4; i < N; i++) g[i] = 8'($urandom);
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < N; cyc++) begin
      v = 1'($urandom_range(0, 1));
      cycle(0, v, g[idx], 0, 0);
      if (v) idx++;
      chk("gap_cnt", 200'(count), 200'(idx));
    end
    if (idx < N) chk("gap_timeout", 200'(idx), 200'(N));
    chk("gap_s0", 200'(matrix[7:0]), 200'h80);
    chk("gap_s1", 200'(matrix[15:8]), 200'h7F);
    chk("gap_s2", 200'(matrix[23:16]), 200'hFF);
    chk("gap_s3", 200'(matrix[31:24]), 200'h00);
    chk("gap_mat", matrix, m_pack());
    cycle(0, 0, 0, 1, 0);

    // Clear mid-load and while FULL
    stream(12, 40, 0);
    cycle(1, 1, 8'h5A, 0, 0);
    chk("clr_cnt", 200'(count), 200'd0);
    chk("clr_mat", matrix, 200'd0);
    stream(N, 100, 0);
    chk("clr_fresh_ov", 200'(out_valid), 200'd1);
    chk("clr_fresh_mat", matrix, m_pack());
    cycle(1, 0, 0, 0, 0);
    chk("clr_full_ov", 200'(out_valid), 200'd0);
    chk("clr_full_cnt", 200'(count), 200'd0);
    chk("clr_full_mat", matrix, 200'd0);

    // Asynchronous reset mid-load and while FULL
    stream(7, 3, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 200'(count), 200'd0);
    chk("arst_mat", matrix, 200'd0);
    chk("arst_ov", 200'(out_valid), 200'd0);
    model_reset();
    #1 rst_n = 1'b1;
    stream(N, 60, 0);
    chk("arst_full_ov", 200'(out_valid), 200'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_full_ov0", 200'(out_valid), 200'd0);
    model_reset();
    #1 rst_n = 1'b1;
    stream(3, 9, 0);
    chk_model("arst_resume");

`ifdef MPU_LOADER_ZERO_PAD_EN
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 8'd5, 0, 0);
    cycle(0, 1, 8'd6, 0, 0);
    cycle(0, 1, 8'd7, 0, 1);
    chk("pad_ov", 200'(out_valid), 200'd1);
    chk("pad_cnt", 200'(count), 200'd25);
    chk("pad_mat", matrix, 200'h070605);
    cycle(0, 0, 0, 1, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)),
`ifdef MPU_LOADER_ZERO_PAD_EN
            ($urandom_range(0, 19) == 0)
`else
            1'b0
`endif
           );
      chk_model("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
- Upstream stage of the MPU datapath. Accepts signed 8-bit elements one per handshake, row-major, and packs them into a flat 5x5 matrix register.
- Presents the complete matrix with a valid/ready handshake to downstream MPU operators: transpose, add, multiply.
- Lets the combinational operators consume a full, stable matrix while streaming happens serially.

Parameters:
- ELEM_W, 8, element width in bits (signed two's complement).
- DIM, 5, matrix dimension. Matrix holds DIM*DIM elements; flat width is ELEM_W*DIM*DIM = 200.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; abandons current load.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  ELEM_W  signed element; row-major order (r0c0, r0c1, ..., r4c4).
- out_valid  out  1  matrix complete and stable.
- out_ready  in  1  downstream consumes matrix.
- matrix  out  ELEM_W*DIM*DIM  packed signed matrix; element k (k = 5*row+col) at bits [ELEM_W*k +: ELEM_W].
- count  out  5  number of elements accepted in current load, 0..25.

Behaviour:
- Reset (rst_n=0, async): state LOAD, count=0, matrix=0, out_valid=0, in_ready=1 once rst_n released.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. In LOAD, each accept writes in_data to slot count, then count+1.
- Accept when count=24: count becomes 25, state becomes FULL on the same edge. out_valid=1 the cycle after the 25th accept (latency 1).
- FULL: matrix and count held stable regardless of in_valid/in_data. Bits beyond an accepted element are never modified.
- FULL & out_ready: on that edge state returns to LOAD and count=0. Matrix contents retained (not cleared) until overwritten slot by slot. in_ready=1 on the following cycle.
- No bypass: an element cannot be accepted in the same cycle a matrix is released.
- clear=1 (synchronous, highest priority after reset): state LOAD, count=0, matrix=0 on next edge. Any same-cycle accept or release is discarded. A FULL matrix under clear is dropped without handshake.
- in_valid with in_ready=0 is ignored; the producer must hold data (standard valid/ready; producer may not drop valid before accept).
- Gaps (in_valid=0) in LOAD leave count and matrix unchanged.
- Values stored bit-exact; no saturation or sign conversion.
- Reset asserted mid-load or while FULL: immediate return to reset state; out_valid drops asynchronously.

Optional Feature:
- Macro MPU_LOADER_ZERO_PAD_EN.
- When defined: extra input port in_last (1 bit). An accept with in_last=1 and count<24 zero-fills slots count+1..24 in the same edge, sets count=25 and enters FULL. in_last on the 25th element behaves as a normal final accept. in_last is ignored when not accepted.
- When undefined: no in_last port; a load completes only after exactly 25 accepts.

Test Plan:
- Stream 1..25 back-to-back, out_ready=1 -> out_valid high exactly 1 cycle after 25th accept. Slot k = k+1 (bits[7:0]=1, bits[199:192]=25). Fed through the transpose stage, slot 1 = 6 and slot 5 = 2. Release 1 cycle later, then in_ready=1.
- Same stream, out_ready=0 for 10 cycles, in_valid held with in_data=99 -> in_ready=0, matrix and count=25 unchanged, no 99 stored. out_ready=1 -> count=0 next cycle.
- Stream -128,127,-1,0,... with random in_valid gaps -> slots bit-exact (0x80,0x7F,0xFF,0x00); count tracks accepts only.
- Assert clear after 12 accepts -> count=0, matrix=0 next cycle. A fresh stream of 25 completes normally. Clear while FULL -> out_valid=0 with no handshake.
- Drop rst_n asynchronously at count=7 -> out_valid=0, count=0, matrix=0 before the next clock edge. Load resumes cleanly after release.
- (MPU_LOADER_ZERO_PAD_EN) 3 elements 5,6,7 with in_last on the 3rd -> FULL next cycle. Slots 0..2 = 5,6,7; slots 3..24 = 0; count=25.
